// File: rtl/pong_defs.sv
// Shared pong definitions: FSM state encoding, 7-segment glyphs, BCD helpers,
// tone half-periods and geometry constants used by paddle and ball logic.
package pong_defs;

    // Score keeper FSM states (2-bit legacy encoding)
    localparam logic [1:0] ST_IDLE     = 2'd0;
    localparam logic [1:0] ST_PLAY     = 2'd1;
    localparam logic [1:0] ST_POINT    = 2'd2;
    localparam logic [1:0] ST_GAMEOVER = 2'd3;

    // Geometry shared with paddle and ball movement
    localparam int unsigned PADDLE_LENGTH = 64;
    localparam int unsigned BALL_SIZE     = 8;

    // Tone half-periods in clk50M cycles
    localparam int unsigned CLK_HZ            = 50_000_000;
    localparam int unsigned HIT_HALF_PERIOD   = CLK_HZ / 2000;   // 1 kHz square wave
    localparam int unsigned POINT_HALF_PERIOD = CLK_HZ / 1000;   // 500 Hz square wave

    // Segment order {g,f,e,d,c,b,a}, active-low
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    function automatic logic [6:0] seg_glyph(input logic [3:0] n);
        logic [6:0] g;
        case (n)
            4'd0:    g = 7'h40;
            4'd1:    g = 7'h79;
            4'd2:    g = 7'h24;
            4'd3:    g = 7'h30;
            4'd4:    g = 7'h19;
            4'd5:    g = 7'h12;
            4'd6:    g = 7'h02;
            4'd7:    g = 7'h78;
            4'd8:    g = 7'h00;
            4'd9:    g = 7'h10;
            default: g = SEG_BLANK;
        endcase
        return g;
    endfunction

    // Two-digit BCD increment; 99 wraps to 00
    function automatic logic [7:0] bcd_inc(input logic [7:0] v);
        logic [7:0] r;
        if (v[3:0] == 4'd9) begin
            r[3:0] = 4'd0;
            r[7:4] = (v[7:4] == 4'd9) ? 4'd0 : v[7:4] + 4'd1;
        end else begin
            r[3:0] = v[3:0] + 4'd1;
            r[7:4] = v[7:4];
        end
        return r;
    endfunction

    function automatic logic [7:0] to_bcd(input int unsigned n);
        return {4'(n / 10), 4'(n % 10)};
    endfunction

endpackage

// File: rtl/pong_score_keeper_seven_seg_mux.sv
// seven_seg_mux: time-multiplexes four BCD digits onto one active-low
// 7-segment display. digits = {d3,d2,d1,d0}; an[3] shows d3.
module seven_seg_mux
    import pong_defs::*;
#(
    parameter int unsigned REFRESH_DIV = 50000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] digits,
    output logic [6:0]  seg,
    output logic [3:0]  an
);

    localparam int unsigned CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [CW-1:0] REFRESH_LAST = CW'(REFRESH_DIV - 1);

    logic [CW-1:0] refresh_cnt;
    logic [1:0]    digit_idx;
    logic          active;
    logic [3:0]    nibble;

    // Refresh counter; each wrap steps the digit index 3->2->1->0->3
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            refresh_cnt <= '0;
            digit_idx   <= '0;
            active      <= 1'b0;
        end else begin
            active <= 1'b1;
            if (refresh_cnt == REFRESH_LAST) begin
                refresh_cnt <= '0;
                digit_idx   <= digit_idx - 2'd1;
            end else begin
                refresh_cnt <= refresh_cnt + CW'(1);
            end
        end
    end

    // Digit enable and segment decode of the selected nibble; dark while in reset
    always_comb begin
        case (digit_idx)
            2'd3:    nibble = digits[15:12];
            2'd2:    nibble = digits[11:8];
            2'd1:    nibble = digits[7:4];
            default: nibble = digits[3:0];
        endcase
        an  = '1;
        seg = SEG_BLANK;
        if (active) begin
            an[digit_idx] = 1'b0;
            seg           = seg_glyph(nibble);
        end
    end

endmodule

// File: rtl/pong_score_keeper.sv
// pong_score_keeper: frame edge detection, serve/point/game-over FSM, BCD
// scores and 7-segment display. Optional tone generator enabled by the
// PONG_SCORE_BEEP_EN macro; without it beep is tied low.
module pong_score_keeper
    import pong_defs::*;
#(
    parameter int unsigned WIN_SCORE    = 11,
    parameter int unsigned SERVE_FRAMES = 60,
    parameter int unsigned REFRESH_DIV  = 50000,
    parameter int unsigned BEEP_FRAMES  = 6
) (
    input  logic       clk50M,
    input  logic       reset,
    input  logic       endofframe,
    input  logic       miss_p1,
    input  logic       miss_p2,
    input  logic       collided,
    input  logic       serve_btn,
    output logic       serve_hold,
    output logic       game_over,
    output logic [7:0] score_p1,
    output logic [7:0] score_p2,
    output logic [6:0] seg,
    output logic [3:0] an,
    output logic       beep
);

    localparam logic [7:0] WIN_BCD    = to_bcd(WIN_SCORE);
    localparam logic [7:0] SERVE_LAST = 8'(SERVE_FRAMES - 1);

    logic [1:0] state;
    logic [7:0] frame_cnt;
    logic       endofframe_q;
    logic       miss_p1_q;
    logic       miss_p2_q;
    logic       frame_tick;
    logic       miss_p1_edge;
    logic       miss_p2_edge;

    assign frame_tick   = endofframe & ~endofframe_q;
    assign miss_p1_edge = frame_tick & miss_p1 & ~miss_p1_q;
    assign miss_p2_edge = frame_tick & miss_p2 & ~miss_p2_q;

    assign serve_hold = (state != ST_PLAY);
    assign game_over  = (state == ST_GAMEOVER);

    // Edge registers, FSM, frame counter and BCD scores
    always_ff @(posedge clk50M or posedge reset) begin
        if (reset) begin
            state        <= ST_IDLE;
            frame_cnt    <= '0;
            endofframe_q <= 1'b0;
            miss_p1_q    <= 1'b0;
            miss_p2_q    <= 1'b0;
            score_p1     <= '0;
            score_p2     <= '0;
        end else begin
            endofframe_q <= endofframe;
            // Sampled miss levels track every frame so a miss held across a
            // point does not score again when play resumes.
            if (frame_tick) begin
                miss_p1_q <= miss_p1;
                miss_p2_q <= miss_p2;
            end
            case (state)
                ST_IDLE: begin
                    if (frame_tick && serve_btn) state <= ST_PLAY;
                end
                ST_PLAY: begin
                    if (miss_p1_edge) begin
                        score_p2  <= bcd_inc(score_p2);
                        frame_cnt <= '0;
                        state     <= ST_POINT;
                    end else if (miss_p2_edge) begin
                        score_p1  <= bcd_inc(score_p1);
                        frame_cnt <= '0;
                        state     <= ST_POINT;
                    end
                end
                ST_POINT: begin
                    if (frame_tick) begin
                        if (frame_cnt == SERVE_LAST) begin
                            frame_cnt <= '0;
                            if (score_p1 == WIN_BCD || score_p2 == WIN_BCD)
                                state <= ST_GAMEOVER;
                            else
                                state <= ST_PLAY;
                        end else begin
                            frame_cnt <= frame_cnt + 8'd1;
                        end
                    end
                end
                default: begin
                    if (frame_tick && serve_btn) begin
                        score_p1 <= '0;
                        score_p2 <= '0;
                        state    <= ST_IDLE;
                    end
                end
            endcase
        end
    end

`ifdef PONG_SCORE_BEEP_EN
    logic        collided_q;
    logic        hit_edge;
    logic        point_edge;
    logic [7:0]  beep_left;
    logic [15:0] beep_half;
    logic [15:0] beep_cnt;
    logic        tone;

    assign hit_edge   = (state == ST_PLAY) & frame_tick & collided & ~collided_q;
    assign point_edge = (state == ST_PLAY) & (miss_p1_edge | miss_p2_edge);
    assign beep       = tone & (beep_left != 8'd0);

    // Tone generator; a point restarts the tone even over a running hit beep
    always_ff @(posedge clk50M or posedge reset) begin
        if (reset) begin
            collided_q <= 1'b0;
            beep_left  <= '0;
            beep_half  <= '0;
            beep_cnt   <= '0;
            tone       <= 1'b0;
        end else begin
            if (frame_tick) collided_q <= collided;
            if (point_edge) begin
                beep_left <= 8'(BEEP_FRAMES);
                beep_half <= 16'(POINT_HALF_PERIOD - 1);
                beep_cnt  <= '0;
                tone      <= 1'b1;
            end else if (hit_edge) begin
                beep_left <= 8'(BEEP_FRAMES);
                beep_half <= 16'(HIT_HALF_PERIOD - 1);
                beep_cnt  <= '0;
                tone      <= 1'b1;
            end else if (beep_left != 8'd0) begin
                if (beep_cnt == beep_half) begin
                    beep_cnt <= '0;
                    tone     <= ~tone;
                end else begin
                    beep_cnt <= beep_cnt + 16'd1;
                end
                if (frame_tick) beep_left <= beep_left - 8'd1;
            end else begin
                tone <= 1'b0;
            end
        end
    end
`else
    logic unused_collided;
    assign unused_collided = collided;
    assign beep = 1'b0;
`endif

    seven_seg_mux #(
        .REFRESH_DIV(REFRESH_DIV)
    ) u_mux (
        .clk    (clk50M),
        .rst    (reset),
        .digits ({score_p1, score_p2}),
        .seg    (seg),
        .an     (an)
    );

endmodule

// File: tb/tb_pong_score_keeper.sv
// Bench for pong_score_keeper: directed scenarios plus randomized frames
// checked against a point-counting game model.
module tb_pong_score_keeper;

    localparam int unsigned WIN   = 11;
    localparam int unsigned SERVE = 60;
    localparam int unsigned RDIV  = 4;
    localparam int unsigned BEEPF = 6;

    logic       clk50M;
    logic       reset;
    logic       endofframe;
    logic       miss_p1;
    logic       miss_p2;
    logic       collided;
    logic       serve_btn;
    logic       serve_hold;
    logic       game_over;
    logic [7:0] score_p1;
    logic [7:0] score_p2;
    logic [6:0] seg;
    logic [3:0] an;
    logic       beep;

    int n_checks = 0;
    int n_fail   = 0;

    // Game model: integer scores and a named phase
    string m_mode;
    int    m_p1, m_p2, m_left;
    bit    m_prev1, m_prev2;
    logic  hold_before;

    // Lit segments per digit, {g,f,e,d,c,b,a}, active-high
    logic [6:0] lit [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                             7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

    pong_score_keeper #(
        .WIN_SCORE    (WIN),
        .SERVE_FRAMES (SERVE),
        .REFRESH_DIV  (RDIV),
        .BEEP_FRAMES  (BEEPF)
    ) dut (
        .clk50M     (clk50M),
        .reset      (reset),
        .endofframe (endofframe),
        .miss_p1    (miss_p1),
        .miss_p2    (miss_p2),
        .collided   (collided),
        .serve_btn  (serve_btn),
        .serve_hold (serve_hold),
        .game_over  (game_over),
        .score_p1   (score_p1),
        .score_p2   (score_p2),
        .seg        (seg),
        .an         (an),
        .beep       (beep)
    );

    initial clk50M = 1'b0;
    always #10 clk50M = ~clk50M;

    function automatic logic [7:0] bcd(input int v);
        return {4'(v / 10), 4'(v % 10)};
    endfunction

    task automatic model_reset();
        m_mode = "idle"; m_p1 = 0; m_p2 = 0; m_left = 0; m_prev1 = 0; m_prev2 = 0;
    endtask

    task automatic model_tick(input bit m1, input bit m2, input bit btn);
        bit e1, e2;
        e1 = m1 && !m_prev1;
        e2 = m2 && !m_prev2;
        m_prev1 = m1;
        m_prev2 = m2;
        if (m_mode == "idle") begin
            if (btn) m_mode = "play";
        end else if (m_mode == "play") begin
            if (e1) begin m_p2++; m_mode = "point"; m_left = SERVE; end
            else if (e2) begin m_p1++; m_mode = "point"; m_left = SERVE; end
        end else if (m_mode == "point") begin
            m_left--;
            if (m_left == 0) m_mode = (m_p1 == WIN || m_p2 == WIN) ? "over" : "play";
        end else begin
            if (btn) begin m_p1 = 0; m_p2 = 0; m_mode = "idle"; end
        end
    endtask

    // One frame: endofframe high for one clock, then low; model stepped with the tick
    task automatic do_frame(input bit m1, input bit m2, input bit col, input bit btn);
        @(negedge clk50M);
        miss_p1 = m1; miss_p2 = m2; collided = col; serve_btn = btn; endofframe = 1'b1;
        #1 hold_before = serve_hold;
        @(posedge clk50M);
        #1 model_tick(m1, m2, btn);
        @(negedge clk50M);
        endofframe = 1'b0;
        @(negedge clk50M);
    endtask

    task automatic test_reset();
        reset = 1'b1; endofframe = 0; miss_p1 = 0; miss_p2 = 0; collided = 0; serve_btn = 0;
        model_reset();
        repeat (3) @(negedge clk50M);
        n_checks++; if (score_p1 !== 8'h00) begin n_fail++; $display("FAIL reset_p1 got %h want 00", score_p1); end
        n_checks++; if (score_p2 !== 8'h00) begin n_fail++; $display("FAIL reset_p2 got %h want 00", score_p2); end
        n_checks++; if (serve_hold !== 1'b1) begin n_fail++; $display("FAIL reset_hold got %b want 1", serve_hold); end
        n_checks++; if (game_over !== 1'b0) begin n_fail++; $display("FAIL reset_gameover got %b want 0", game_over); end
        n_checks++; if (an !== 4'b1111) begin n_fail++; $display("FAIL reset_an got %b want 1111", an); end
        n_checks++; if (seg !== 7'h7F) begin n_fail++; $display("FAIL reset_seg got %h want 7f", seg); end
        n_checks++; if (beep !== 1'b0) begin n_fail++; $display("FAIL reset_beep got %b want 0", beep); end
        reset = 1'b0;
        repeat (2) @(negedge clk50M);
    endtask

    task automatic test_serve();
        do_frame(0, 0, 0, 1);
        n_checks++; if (hold_before !== 1'b1) begin n_fail++; $display("FAIL serve_hold_at_tick got %b want 1", hold_before); end
        n_checks++; if (serve_hold !== 1'b0) begin n_fail++; $display("FAIL serve_hold_after_tick got %b want 0", serve_hold); end
        do_frame(0, 0, 0, 1);
        n_checks++; if (serve_hold !== 1'b0) begin n_fail++; $display("FAIL serve_second_tick got %b want 0", serve_hold); end
    endtask

    task automatic test_miss_held();
        int cnt;
        bit dropped;
        do_frame(1, 0, 0, 0);
        n_checks++; if (serve_hold !== 1'b1) begin n_fail++; $display("FAIL held_hold_rise got %b want 1", serve_hold); end
        cnt = 0;
        repeat (4) begin do_frame(1, 0, 0, 0); cnt++; end
        dropped = 0;
        for (int i = 0; i < 200 && !dropped; i++) begin
            do_frame(0, 0, 0, 0);
            cnt++;
            if (serve_hold === 1'b0) dropped = 1;
        end
        n_checks++; if (!dropped) begin n_fail++; $display("FAIL held_timeout serve_hold still 1 after 200 frames"); end
        n_checks++; if (cnt != SERVE) begin n_fail++; $display("FAIL held_frames got %0d want %0d", cnt, SERVE); end
        n_checks++; if (score_p2 !== 8'h01) begin n_fail++; $display("FAIL held_p2 got %h want 01", score_p2); end
        n_checks++; if (score_p1 !== 8'h00) begin n_fail++; $display("FAIL held_p1 got %h want 00", score_p1); end
    endtask

    task automatic score_for_p1();
        do_frame(0, 1, 0, 0);
        repeat (SERVE) do_frame(0, 0, 0, 0);
    endtask

    task automatic test_bcd_carry();
        int d, prev_d, nib;
        logic [6:0] want;
        repeat (9) score_for_p1();
        n_checks++; if (score_p1 !== 8'h09) begin n_fail++; $display("FAIL carry_pre got %h want 09", score_p1); end
        do_frame(0, 1, 0, 0);
        n_checks++; if (score_p1 !== 8'h10) begin n_fail++; $display("FAIL carry_bcd got %h want 10", score_p1); end
        prev_d = -1;
        for (int c = 0; c < 10 * RDIV; c++) begin
            @(negedge clk50M);
            n_checks++;
            if ($countones(~an) != 1) begin
                n_fail++; $display("FAIL disp_onehot got an=%b want one low bit", an);
            end else begin
                d = 0;
                for (int b = 0; b < 4; b++) if (an[b] == 1'b0) d = b;
                case (d)
                    3: nib = m_p1 / 10;
                    2: nib = m_p1 % 10;
                    1: nib = m_p2 / 10;
                    default: nib = m_p2 % 10;
                endcase
                want = ~lit[nib];
                n_checks++; if (seg !== want) begin n_fail++; $display("FAIL disp_seg digit %0d got %h want %h", d, seg, want); end
                if (prev_d >= 0 && d != prev_d) begin
                    n_checks++; if (d != (prev_d + 3) % 4) begin n_fail++; $display("FAIL disp_order got %0d want %0d", d, (prev_d + 3) % 4); end
                end
                prev_d = d;
            end
        end
        repeat (SERVE) do_frame(0, 0, 0, 0);
    endtask

    task automatic test_game_over();
        score_for_p1();
        n_checks++; if (score_p1 !== bcd(WIN)) begin n_fail++; $display("FAIL over_p1 got %h want %h", score_p1, bcd(WIN)); end
        n_checks++; if (game_over !== 1'b1) begin n_fail++; $display("FAIL over_flag got %b want 1", game_over); end
        n_checks++; if (serve_hold !== 1'b1) begin n_fail++; $display("FAIL over_hold got %b want 1", serve_hold); end
        do_frame(1, 0, 1, 0); do_frame(0, 0, 0, 0); do_frame(0, 1, 0, 0); do_frame(0, 0, 0, 0);
        n_checks++; if (score_p1 !== 8'h11) begin n_fail++; $display("FAIL over_frozen_p1 got %h want 11", score_p1); end
        n_checks++; if (score_p2 !== 8'h01) begin n_fail++; $display("FAIL over_frozen_p2 got %h want 01", score_p2); end
        do_frame(0, 0, 0, 1);
        n_checks++; if (score_p1 !== 8'h00 || score_p2 !== 8'h00) begin n_fail++; $display("FAIL over_clear got %h/%h want 00/00", score_p1, score_p2); end
        n_checks++; if (game_over !== 1'b0) begin n_fail++; $display("FAIL over_exit got %b want 0", game_over); end
        do_frame(0, 0, 0, 0);
        n_checks++; if (serve_hold !== 1'b1) begin n_fail++; $display("FAIL over_idle_hold got %b want 1", serve_hold); end
    endtask

    task automatic test_simultaneous();
        do_frame(0, 0, 0, 1);
        do_frame(1, 1, 0, 0);
        n_checks++; if (score_p2 !== 8'h01) begin n_fail++; $display("FAIL both_p2 got %h want 01", score_p2); end
        n_checks++; if (score_p1 !== 8'h00) begin n_fail++; $display("FAIL both_p1 got %h want 00", score_p1); end
        repeat (SERVE) do_frame(0, 0, 0, 0);
        n_checks++; if (serve_hold !== 1'b0) begin n_fail++; $display("FAIL both_resume got %b want 0", serve_hold); end
    endtask

    task automatic test_random();
        bit m1, m2, col, btn;
        for (int f = 0; f < 600; f++) begin
            m1  = ($urandom_range(0, 5) == 0);
            m2  = ($urandom_range(0, 5) == 0);
            col = ($urandom_range(0, 3) == 0);
            btn = ($urandom_range(0, 3) == 0);
            do_frame(m1, m2, col, btn);
            n_checks++; if (score_p1 !== bcd(m_p1)) begin n_fail++; $display("FAIL rand_p1 frame %0d got %h want %h", f, score_p1, bcd(m_p1)); end
            n_checks++; if (score_p2 !== bcd(m_p2)) begin n_fail++; $display("FAIL rand_p2 frame %0d got %h want %h", f, score_p2, bcd(m_p2)); end
            n_checks++; if (serve_hold !== (m_mode != "play")) begin n_fail++; $display("FAIL rand_hold frame %0d got %b want %b", f, serve_hold, m_mode != "play"); end
            n_checks++; if (game_over !== (m_mode == "over")) begin n_fail++; $display("FAIL rand_over frame %0d got %b want %b", f, game_over, m_mode == "over"); end
`ifndef PONG_SCORE_BEEP_EN
            n_checks++; if (beep !== 1'b0) begin n_fail++; $display("FAIL rand_beep frame %0d got %b want 0", f, beep); end
`endif
        end
    endtask

    task automatic test_async_reset();
        do_frame(0, 0, 0, 1);
        do_frame(0, 1, 0, 0);
        @(posedge clk50M);
        #3 reset = 1'b1;
        #1;
        n_checks++; if (score_p1 !== 8'h00 || score_p2 !== 8'h00) begin n_fail++; $display("FAIL areset_scores got %h/%h want 00/00", score_p1, score_p2); end
        n_checks++; if (serve_hold !== 1'b1) begin n_fail++; $display("FAIL areset_hold got %b want 1", serve_hold); end
        n_checks++; if (an !== 4'b1111 || seg !== 7'h7F) begin n_fail++; $display("FAIL areset_disp got %b/%h want 1111/7f", an, seg); end
        model_reset();
        @(negedge clk50M);
        reset = 1'b0;
        do_frame(1, 1, 0, 0);
        n_checks++; if (serve_hold !== 1'b1 || score_p2 !== 8'h00) begin n_fail++; $display("FAIL areset_idle got hold=%b p2=%h want 1/00", serve_hold, score_p2); end
    endtask

`ifdef PONG_SCORE_BEEP_EN
    task automatic test_beep();
        do_frame(0, 0, 0, 1);
        do_frame(0, 0, 1, 0);
        repeat (BEEPF + 1) do_frame(0, 0, 0, 0);
        n_checks++; if (beep !== 1'b0) begin n_fail++; $display("FAIL beep_end got %b want 0", beep); end
    endtask
`endif

    initial begin
        test_reset();
        test_serve();
        test_miss_held();
        test_bcd_carry();
        test_game_over();
        test_simultaneous();
        test_random();
        test_async_reset();
`ifdef PONG_SCORE_BEEP_EN
        test_beep();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
